// File: rtl/smul_pkg.sv
// smul_pkg: shared types and constants for the smul_seq multiplier.
// State encoding, mode encoding and the iteration-counter width helper.
package smul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } smul_state_t;

  localparam logic SMUL_UNSIGNED = 1'b0;
  localparam logic SMUL_SIGNED   = 1'b1;

  function automatic int smul_cw(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/smul_seq_ctrl.sv
// smul_seq_ctrl: state, iteration count, handshake and last-step
// subtract select for the shift-add multiplier datapath.
import smul_pkg::*;

module smul_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mode,
  output logic ready,
  output logic done,
  output logic load,
  output logic step,
  output logic sub
);

  localparam int CW = smul_cw(WIDTH);

  smul_state_t state, state_nxt;
  logic [CW-1:0] count;
  logic          last;

  assign last = (count == '0);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and datapath strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    sub       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        sub  = mode && last;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // iteration counter and registered done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= step && last;
      if (load)
        count <= CW'(WIDTH - 1);
      else if (step && !last)
        count <= count - 1'b1;
    end
  end

  assign ready = (state == IDLE) && !reset;

endmodule

// File: rtl/smul_seq.sv
// smul_seq: WIDTH-generic signed/unsigned shift-add multiplier.
// Optional saturated output and overflow flag with SMUL_SAT_EN.
import smul_pkg::*;

module smul_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] word1,
  input  logic [WIDTH-1:0] word2,
  output logic [2*WIDTH-1:0] product,
  output logic             ready,
  output logic             done
`ifdef SMUL_SAT_EN
  ,
  output logic [WIDTH-1:0] sat_product,
  output logic             ovf
`endif
);

  logic             load, step, sub;
  logic [WIDTH-1:0] mcand;
  logic             mode;
  logic [WIDTH-1:0] hi;
  logic [WIDTH:0]   hi_x, m_x, addend, sum;

  smul_seq_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .ready (ready),
    .done  (done),
    .load  (load),
    .step  (step),
    .sub   (sub)
  );

  assign hi   = product[2*WIDTH-1:WIDTH];
  assign hi_x = {mode & hi[WIDTH-1], hi};
  assign m_x  = {mode & mcand[WIDTH-1], mcand};

  // one add or subtract of the extended multiplicand per step
  always_comb begin
    addend = product[0] ? m_x : '0;
    sum    = sub ? (hi_x - addend) : (hi_x + addend);
  end

  // operand capture and product shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mode    <= SMUL_UNSIGNED;
      product <= '0;
    end else if (load) begin
      mcand   <= word1;
      mode    <= signed_mode;
      product <= {{WIDTH{1'b0}}, word2};
    end else if (step) begin
      product <= {sum, product[WIDTH-1:1]};
    end
  end

`ifdef SMUL_SAT_EN
  logic [WIDTH:0] top_s;
  logic           ovf_s, ovf_u;

  assign top_s = product[2*WIDTH-1:WIDTH-1];
  assign ovf_s = !((&top_s) || !(|top_s));
  assign ovf_u = |product[2*WIDTH-1:WIDTH];

  // clamp to the nearer representable bound on overflow
  always_comb begin
    ovf         = 1'b0;
    sat_product = product[WIDTH-1:0];
    if (mode == SMUL_SIGNED) begin
      ovf = ovf_s;
      if (ovf_s)
        sat_product = product[2*WIDTH-1]
          ? {1'b1, {(WIDTH-1){1'b0}}}
          : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      ovf = ovf_u;
      if (ovf_u) sat_product = '1;
    end
  end
`endif

endmodule

// File: tb/tb_smul_seq.sv
// tb_smul_seq: table-driven and sequence checks of smul_seq,
// WIDTH=8 with a scoreboard queue plus WIDTH=4 exhaustive.
module tb_smul_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        smode = 1'b0;
  logic [7:0]  w1 = '0, w2 = '0;
  logic [15:0] product;
  logic        ready, done;

  logic        start4 = 1'b0;
  logic        smode4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  product4;
  logic        ready4, done4;

`ifdef SMUL_SAT_EN
  logic [7:0] sat_product;
  logic       ovf;
  logic [3:0] sat4;
  logic       ovf4;
`endif

  int passed = 0;
  int total  = 0;
  logic [15:0] sbq[$];

  always #5 clk = ~clk;

  smul_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .signed_mode(smode), .word1(w1), .word2(w2),
    .product(product), .ready(ready), .done(done)
`ifdef SMUL_SAT_EN
    , .sat_product(sat_product), .ovf(ovf)
`endif
  );

  smul_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .signed_mode(smode4), .word1(a4), .word2(b4),
    .product(product4), .ready(ready4), .done(done4)
`ifdef SMUL_SAT_EN
    , .sat_product(sat4), .ovf(ovf4)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] ref8(input logic s,
      input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ax, bx;
    ax = s ? {{8{a[7]}}, a} : {8'h00, a};
    bx = s ? {{8{b[7]}}, b} : {8'h00, b};
    return ax * bx;
  endfunction

  function automatic logic [7:0] ref4(input logic s,
      input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ax, bx;
    ax = s ? {{4{a[3]}}, a} : {4'h0, a};
    bx = s ? {{4{b[3]}}, b} : {4'h0, b};
    return ax * bx;
  endfunction

`ifdef SMUL_SAT_EN
  task automatic chk_sat(input logic s, input logic [15:0] p);
    logic [7:0] es;
    logic       eo;
    int         v;
    v  = s ? int'($signed(p)) : int'(p);
    eo = s ? (v > 127 || v < -128) : (v > 255);
    es = p[7:0];
    if (eo) es = s ? (v < 0 ? 8'h80 : 8'h7F) : 8'hFF;
    chk("ovf", 32'(ovf), 32'(eo));
    chk("sat_product", 32'(sat_product), 32'(es));
  endtask
`endif

  task automatic do_op(input logic s, input logic [7:0] a,
                       input logic [7:0] b, input string nm);
    int n;
    bit rbad;
    logic [15:0] e;
    @(negedge clk);
    chk({nm, " ready_idle"}, 32'(ready), 32'd1);
    start = 1'b1; smode = s; w1 = a; w2 = b;
    sbq.push_back(ref8(s, a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; w1 = ~a; w2 = ~b; smode = ~s;
    n = 1; rbad = 0;
    while (!done && n < 40) begin
      if (ready) rbad = 1;
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'd9);
    chk({nm, " ready_run"}, 32'(rbad), 32'd0);
    e = sbq.pop_front();
    chk({nm, " product"}, 32'(product), 32'(e));
`ifdef SMUL_SAT_EN
    chk_sat(s, e);
`endif
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vt[$];

  initial begin
    int n, d1, d2;
    bit seen;
    logic [15:0] e;

    vt.push_back('{1'b1, 8'h03, 8'hFB, 16'hFFF1});
    vt.push_back('{1'b1, 8'h80, 8'h80, 16'h4000});
    vt.push_back('{1'b1, 8'hFF, 8'hFF, 16'h0001});
    vt.push_back('{1'b1, 8'h7F, 8'h80, 16'hC080});
    vt.push_back('{1'b0, 8'hFF, 8'hFF, 16'hFE01});
    vt.push_back('{1'b0, 8'h80, 8'h02, 16'h0100});
    vt.push_back('{1'b1, 8'h64, 8'h64, 16'h2710});
    vt.push_back('{1'b1, 8'h9C, 8'h64, 16'hD8F0});
    vt.push_back('{1'b1, 8'h05, 8'hFA, 16'hFFE2});
    vt.push_back('{1'b0, 8'h00, 8'hA5, 16'h0000});

    repeat (2) @(negedge clk);
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst product", 32'(product), 32'd0);
`ifdef SMUL_SAT_EN
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst sat", 32'(sat_product), 32'd0);
`endif
    reset = 1'b0;
    #1;
    chk("ready after reset", 32'(ready), 32'd1);

    foreach (vt[i]) begin
      chk($sformatf("table ref %0d", i),
          32'(ref8(vt[i].s, vt[i].a, vt[i].b)), 32'(vt[i].p));
      do_op(vt[i].s, vt[i].a, vt[i].b, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++)
      do_op(1'($urandom), 8'($urandom), 8'($urandom),
            $sformatf("rnd%0d", i));

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; smode = 1'b1; w1 = 8'h03; w2 = 8'hFB;
    sbq.push_back(16'hFFF1);
    sbq.push_back(16'hFE01);
    @(posedge clk);
    @(negedge clk);
    smode = 1'b0; w1 = 8'hFF; w2 = 8'hFF;
    d1 = -1; d2 = -1;
    for (int i = 1; i < 30; i++) begin
      if (done) begin
        e = sbq.pop_front();
        chk("b2b product", 32'(product), 32'(e));
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
      if (d1 > 0 && i == d1 + 1) start = 1'b0;
      @(negedge clk);
    end
    chk("b2b first done", 32'(d1), 32'd9);
    chk("b2b spacing", 32'(d2 - d1), 32'd9);
    sbq.delete();

    // start pulsed during RUN is ignored
    @(negedge clk);
    start = 1'b1; smode = 1'b1; w1 = 8'h7F; w2 = 8'h80;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; smode = 1'b0; w1 = 8'h11; w2 = 8'h22;
    @(negedge clk);
    start = 1'b0;
    n = 4;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ignore latency", 32'(n), 32'd9);
    chk("ignore product", 32'(product), 32'hC080);
    @(negedge clk);
    chk("ignore no restart", 32'(ready), 32'd1);

    // reset mid-operation
    start = 1'b1; smode = 1'b0; w1 = 8'hFF; w2 = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort product", 32'(product), 32'd0);
    chk("abort ready", 32'(ready), 32'd0);
    @(negedge clk);
    chk("abort done", 32'(done), 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) chk("abort ready after", 32'(ready), 32'd1);
      if (done) seen = 1;
    end
    chk("abort no done", 32'(seen), 32'd0);
    chk("abort product hold", 32'(product), 32'd0);

    // WIDTH=4 exhaustive, signed and unsigned
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          @(negedge clk);
          start4 = 1'b1; smode4 = 1'(s);
          a4 = 4'(a); b4 = 4'(b);
          @(posedge clk);
          @(negedge clk);
          start4 = 1'b0;
          n = 1;
          while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
          end
          total++;
          if (n == 5 &&
              product4 == ref4(1'(s), 4'(a), 4'(b)))
            passed++;
          else
            $display("FAIL w4 s=%0d a=%0h b=%0h: got %0h lat %0d expected %0h lat 5",
                     s, a, b, product4, n, ref4(1'(s), 4'(a), 4'(b)));
        end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/smul_seq.md
# smul_seq

Parametrised sequential multiplier, the WIDTH-generic successor of the fixed 4-bit signed shift-add multiplier. It takes two WIDTH-bit operands on a start/ready handshake and produces a 2·WIDTH-bit product after WIDTH iterations, using one add/subtract per cycle. Each operation selects signed (two's complement) or unsigned mode. It sits beside the arithmetic datapath blocks as the area-cheap multiplier for non-throughput-critical paths.

## Interface
- WIDTH, 8: operand width in bits, ≥ 2; product is 2·WIDTH bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while ready=1.
- signed_mode  in  1  1 = operands and product two's complement, 0 = unsigned; captured with start.
- word1  in  WIDTH  multiplicand; captured with start.
- word2  in  WIDTH  multiplier; captured with start.
- product  out  2·WIDTH  result register; valid from done until the next accepted start.
- ready  out  1  idle and able to accept start.
- done  out  1  one-cycle pulse when product becomes valid.
- sat_product  out  WIDTH  saturated result, present only with SMUL_SAT_EN.
- ovf  out  1  product does not fit in WIDTH bits, present only with SMUL_SAT_EN.

## Operation
- States: IDLE, RUN.
- Reset values: state=IDLE, count=0, multiplicand=0, mode=0, product=0, done=0, ready=0 while reset is high. ready = (state==IDLE) && !reset.
- Accept: in IDLE with start=1, the block loads multiplicand←word1, mode←signed_mode, product←{WIDTH'b0, word2}, count←WIDTH-1, and goes to RUN.
- RUN step, every cycle, where hi=product[2W-1:W] and m0=product[0]:
  - ext(x) is x extended to WIDTH+1 bits: sign-extended if mode=1, zero-extended if mode=0.
  - sub = mode && (count==0).
  - sum = ext(hi) − (m0 ? ext(multiplicand) : 0) when sub, else ext(hi) + (m0 ? ext(multiplicand) : 0). sum is WIDTH+1 bits and wraps modulo 2^(WIDTH+1).
  - product ← {sum, product[WIDTH-1:1]}.
  - A step with m0=0 is therefore the arithmetic shift in signed mode and the logical shift in unsigned mode.
- count==0 in RUN: after the step, state←IDLE and done←1. Otherwise count←count−1.
- done is 0 in every other cycle. product holds its value in IDLE.
- start while in RUN is ignored. It is not queued.
- Operand changes after acceptance have no effect.
- reset mid-operation aborts immediately to reset values. No done is issued.
- Results are exact for all operand pairs. The signed product ranges from −2^(2W−2)+2^(W−1) to 2^(2W−2); the unsigned product reaches at most (2^W−1)².

## Timing
- Start sampled at edge E. RUN steps occur at edges E+1 … E+WIDTH.
- done=1 and ready=1 in the cycle after edge E+WIDTH.
- Latency from the start-sampling edge to done is WIDTH edges of stepping after the load edge, i.e. WIDTH+1 clocks per operation.
- Back-to-back: start asserted in the done cycle is accepted at the next edge. Throughput is one result per WIDTH+1 cycles.
- product, done and ready are registered or derived from registered state only. There is no combinational path from any input to any output except reset→ready.

## Configuration
- SMUL_SAT_EN defined:
  - Adds the sat_product and ovf ports, both combinational from product and mode.
  - Signed mode: ovf=1 when product is outside [−2^(W−1), 2^(W−1)−1]; sat_product clamps to the nearer bound.
  - Unsigned mode: ovf=1 when product > 2^W−1; sat_product clamps to 2^W−1.
  - When ovf=0, sat_product = product[W−1:0].
  - Both outputs are 0 after reset.
- SMUL_SAT_EN undefined: the ports and logic are absent. All other behaviour is identical.

## Structure
- Package smul_pkg holds:
  - the state typedef (IDLE, RUN);
  - the count-width function $clog2(WIDTH);
  - the mode encoding constants SMUL_UNSIGNED=0 and SMUL_SIGNED=1.
- One sub-module, smul_seq_ctrl: the state, count, handshake and sub generation. It drives load and step to the datapath kept in smul_seq.

## Test plan
- WIDTH=8, signed: word1=0x03, word2=0xFB (3×−5) → product=0xFFF1 with done exactly 9 clocks after the start edge; ready=0 throughout RUN.
- Signed 0x80×0x80 (−128×−128) → 0x4000. Signed 0xFF×0xFF (−1×−1) → 0x0001. Signed 0x7F×0x80 → 0xC080.
- Unsigned 0xFF×0xFF → 0xFE01. Unsigned 0x80×0x02 → 0x0100. Two operations back-to-back with start held high → two done pulses 9 clocks apart.
- Pulse start again 3 cycles into RUN with new operands → ignored; the original result is produced. Assert reset 4 cycles into RUN → product=0, no done, ready=1 one cycle after reset falls.
- SMUL_SAT_EN, signed 0x64×0x64 (10000) → ovf=1, sat_product=0x7F. Signed 0x9C×0x64 → sat_product=0x80. Signed 0x05×0xFA → ovf=0, sat_product=0xE2.
- WIDTH=4 and WIDTH=16 exhaustive (4) / random (16) signed and unsigned runs against a reference multiply → all products match with latency WIDTH+1.
